// File: rtl/csa_pipe.sv
// csa_pipe: pipelined carry-select adder with a valid/ready stream interface.
//
// The operand is split into BLK-bit blocks, and there is one pipeline stage per
// block (L = WIDTH/BLK stages). Each stage forms both candidate block sums, one
// for carry-in 0 and one for carry-in 1. The carry arriving at that block picks
// between them. The stage then registers:
//   - the growing finished sum,
//   - the carry into the next block,
//   - the operands, which later blocks still need.
// The registers of stage L-1 drive the outputs directly.
//
// Backpressure: a stage may load when it is empty or when the stage after it
// is able to move. The ready path ripples combinationally from out_ready to
// in_ready.
//
// WIDTH must be a multiple of BLK and at least BLK.
//
// Optional feature: define CSA_OVF_EN to add the signed-overflow output 'ovf'.
// With it, the operand sign bits travel down the pipe next to the data.
module csa_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef CSA_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int L = WIDTH / BLK;

    // Per-stage pipeline registers and their next-state values.
    logic [L-1:0]     v_q, v_d;
    logic [L-1:0]     c_q, c_d;
    logic [WIDTH-1:0] sum_q [L];
    logic [WIDTH-1:0] sum_d [L];
    logic [WIDTH-1:0] opx_q [L];
    logic [WIDTH-1:0] opx_d [L];
    logic [WIDTH-1:0] opy_q [L];
    logic [WIDTH-1:0] opy_d [L];

    // What each stage sees from upstream. Stage 0 sees the input port.
    logic [L-1:0]     up_v;
    logic [L-1:0]     up_c;
    logic [WIDTH-1:0] up_x   [L];
    logic [WIDTH-1:0] up_y   [L];
    logic [WIDTH-1:0] up_sum [L];

    // Carry-select candidates and the selected block result.
    logic [BLK:0]     sum0 [L];
    logic [BLK:0]     sum1 [L];
    logic [BLK:0]     blk  [L];

    // Ready chain. rdy[k] means stage k may load this cycle.
    logic [L-1:0]     rdy;
    logic             rdy_nxt;

`ifdef CSA_OVF_EN
    logic             xs_q  [L];
    logic             xs_d  [L];
    logic             ys_q  [L];
    logic             ys_d  [L];
    logic             up_xs [L];
    logic             up_ys [L];
    logic             ovf_q, ovf_d;
`endif

    // Ready ripples backwards: a stage can take new data if it is empty or its successor moves.
    always_comb begin
        rdy     = '0;
        rdy_nxt = out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            rdy[k]  = !v_q[k] || rdy_nxt;
            rdy_nxt = rdy[k];
        end
    end

    assign in_ready = rdy[0] && !rst;

    // Route upstream sources: the input port feeds stage 0, and stage k-1 feeds stage k.
    always_comb begin
        up_v[0]   = in_valid;
        up_c[0]   = cin;
        up_x[0]   = x;
        up_y[0]   = y;
        up_sum[0] = '0;
`ifdef CSA_OVF_EN
        up_xs[0]  = x[WIDTH-1];
        up_ys[0]  = y[WIDTH-1];
`endif
        for (int k = 1; k < L; k++) begin
            up_v[k]   = v_q[k-1];
            up_c[k]   = c_q[k-1];
            up_x[k]   = opx_q[k-1];
            up_y[k]   = opy_q[k-1];
            up_sum[k] = sum_q[k-1];
`ifdef CSA_OVF_EN
            up_xs[k]  = xs_q[k-1];
            up_ys[k]  = ys_q[k-1];
`endif
        end
    end

    // Per-stage carry-select add. Load from upstream when ready, otherwise hold.
    always_comb begin
        v_d = v_q;
        c_d = c_q;
        for (int k = 0; k < L; k++) begin
            sum0[k]  = {1'b0, up_x[k][k*BLK +: BLK]} + {1'b0, up_y[k][k*BLK +: BLK]};
            sum1[k]  = {1'b0, up_x[k][k*BLK +: BLK]} + {1'b0, up_y[k][k*BLK +: BLK]}
                       + {{BLK{1'b0}}, 1'b1};
            blk[k]   = up_c[k] ? sum1[k] : sum0[k];
            sum_d[k] = sum_q[k];
            opx_d[k] = opx_q[k];
            opy_d[k] = opy_q[k];
`ifdef CSA_OVF_EN
            xs_d[k]  = xs_q[k];
            ys_d[k]  = ys_q[k];
`endif
            if (rdy[k]) begin
                v_d[k]                 = up_v[k];
                c_d[k]                 = blk[k][BLK];
                sum_d[k]               = up_sum[k];
                sum_d[k][k*BLK +: BLK] = blk[k][BLK-1:0];
                opx_d[k]               = up_x[k];
                opy_d[k]               = up_y[k];
`ifdef CSA_OVF_EN
                xs_d[k]                = up_xs[k];
                ys_d[k]                = up_ys[k];
`endif
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

`ifdef CSA_OVF_EN
    // Overflow: the operand signs agree, but the sign of the sum differs from them.
    always_comb begin
        if (rdy[L-1]) begin
            ovf_d = (up_xs[L-1] == up_ys[L-1]) && (sum_d[L-1][WIDTH-1] != up_xs[L-1]);
        end else begin
            ovf_d = ovf_q;
        end
    end
`endif

    // Pipeline state register. Reset empties every stage and zeroes the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < L; k++) begin
                sum_q[k] <= '0;
                opx_q[k] <= '0;
                opy_q[k] <= '0;
`ifdef CSA_OVF_EN
                xs_q[k]  <= 1'b0;
                ys_q[k]  <= 1'b0;
`endif
            end
`ifdef CSA_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < L; k++) begin
                sum_q[k] <= sum_d[k];
                opx_q[k] <= opx_d[k];
                opy_q[k] <= opy_d[k];
`ifdef CSA_OVF_EN
                xs_q[k]  <= xs_d[k];
                ys_q[k]  <= ys_d[k];
`endif
            end
`ifdef CSA_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign s         = sum_q[L-1];
    assign cout      = c_q[L-1];
    assign out_valid = v_q[L-1];
`ifdef CSA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
